// File: rtl/tmr_voter_pkg.sv
// Shared types and constants for the TMR majority voter and its per-channel fault monitors.
package tmr_voter_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } chanState_e;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  localparam int RUN_CNT_WIDTH = 8;

endpackage

// File: rtl/tmr_chan_monitor.sv
// Persistence tracker for one voter channel: flags the channel faulty after THRESH
// consecutive mismatching cycles; the flag is sticky until clr or rst.
module tmr_chan_monitor
  import tmr_voter_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic mis_in,
  output logic fault
);

  localparam logic [RUN_CNT_WIDTH-1:0] THRESH_R = RUN_CNT_WIDTH'(THRESH);

  chanState_e                state, effState, stateNext;
  logic [RUN_CNT_WIDTH-1:0]  run, effRun, runNext;

  // clr restarts the tracker from OK, then the current mismatch is applied on top.
  assign effState = clr ? OK : state;
  assign effRun   = clr ? '0 : run;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stateNext = effState;
    runNext   = effRun;
    case (effState)
      OK: begin
        if (mis_in) begin
          runNext   = RUN_CNT_WIDTH'(1);
          stateNext = (THRESH == 1) ? FAULT : SUSPECT;
        end
      end
      SUSPECT: begin
        if (mis_in) begin
          runNext = effRun + RUN_CNT_WIDTH'(1);
          if (runNext == THRESH_R) stateNext = FAULT;
        end else begin
          runNext   = '0;
          stateNext = OK;
        end
      end
      FAULT: begin
        stateNext = FAULT;
      end
      default: begin
        stateNext = OK;
        runNext   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OK;
      run   <= '0;
      fault <= 1'b0;
    end else begin
      state <= stateNext;
      run   <= runNext;
      fault <= (stateNext == FAULT);
    end
  end

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered bitwise majority voter for three redundant bus copies, with per-channel
// mismatch reporting, sticky flags, a saturating error-event counter and fault monitors.
module tmr_voter_monitor
  import tmr_voter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int THRESH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  input  logic                 clr,
  output logic [WIDTH-1:0]     out,
  output logic                 tmr_err,
  output logic [2:0]           mis,
  output logic [2:0]           mis_sticky,
  output logic [2:0]           fault,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     vote;
  logic [2:0]           misNext;
  logic                 errNext;
  logic [CNT_WIDTH-1:0] cntBase, cntNext;

  assign vote          = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
  assign misNext[CH_A] = |(in_a ^ vote);
  assign misNext[CH_B] = |(in_b ^ vote);
  assign misNext[CH_C] = |(in_c ^ vote);
  assign errNext       = |misNext;

  // Clear takes effect first, so a clear coinciding with an error leaves a count of one.
  always_comb begin
    cntBase = clr ? '0 : err_cnt;
    cntNext = cntBase;
    if (errNext && (cntBase != CNT_MAX)) cntNext = cntBase + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      tmr_err    <= 1'b0;
      mis        <= '0;
      mis_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      out        <= vote;
      tmr_err    <= errNext;
      mis        <= misNext;
      mis_sticky <= (clr ? 3'b000 : mis_sticky) | misNext;
      err_cnt    <= cntNext;
    end
  end

  tmr_chan_monitor #(.THRESH(THRESH)) chanA (
    .clk(clk), .rst(rst), .clr(clr), .mis_in(misNext[CH_A]), .fault(fault[CH_A])
  );

  tmr_chan_monitor #(.THRESH(THRESH)) chanB (
    .clk(clk), .rst(rst), .clr(clr), .mis_in(misNext[CH_B]), .fault(fault[CH_B])
  );

  tmr_chan_monitor #(.THRESH(THRESH)) chanC (
    .clk(clk), .rst(rst), .clr(clr), .mis_in(misNext[CH_C]), .fault(fault[CH_C])
  );

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Self-checking bench for tmr_voter_monitor: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_tmr_voter_monitor;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int THRESH    = 3;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clr = 1'b0;
  logic [WIDTH-1:0]     in_a = '0, in_b = '0, in_c = '0;
  logic [WIDTH-1:0]     out;
  logic                 tmr_err;
  logic [2:0]           mis, mis_sticky, fault;
  logic [CNT_WIDTH-1:0] err_cnt;

  tmr_voter_monitor #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .clr(clr),
    .out(out), .tmr_err(tmr_err), .mis(mis), .mis_sticky(mis_sticky),
    .fault(fault), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain per-bit head counts and per-channel consecutive-run counts.
  int          mOut, mErr, mMis, mSticky, mCnt;
  int          runLen[3];
  bit          faulted[3];

  task automatic modelStep(input logic [WIDTH-1:0] a, b, c, input logic clrV, rstV);
    int v, m, ones, fv;
    int chVal[3];
    if (rstV) begin
      mOut = 0; mErr = 0; mMis = 0; mSticky = 0; mCnt = 0;
      for (int k = 0; k < 3; k++) begin runLen[k] = 0; faulted[k] = 0; end
      return;
    end
    v = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      if (ones >= 2) v += (1 << i);
    end
    chVal[0] = int'(a); chVal[1] = int'(b); chVal[2] = int'(c);
    m = 0;
    for (int k = 0; k < 3; k++) if (chVal[k] != v) m += (1 << k);
    mOut = v;
    mMis = m;
    mErr = (m != 0) ? 1 : 0;
    mSticky = (clrV ? 0 : mSticky) | m;
    if (clrV) mCnt = 0;
    if (mErr == 1 && mCnt < CNT_MAX) mCnt++;
    for (int k = 0; k < 3; k++) begin
      if (clrV) begin runLen[k] = 0; faulted[k] = 0; end
      if (!faulted[k]) begin
        if (((m >> k) & 1) == 1) runLen[k]++;
        else runLen[k] = 0;
        if (runLen[k] >= THRESH) faulted[k] = 1;
      end
    end
  endtask

  task automatic compareAll();
    int fv;
    fv = 0;
    for (int k = 0; k < 3; k++) if (faulted[k]) fv += (1 << k);
    check("out",        32'(out),        32'(mOut));
    check("tmr_err",    32'(tmr_err),    32'(mErr));
    check("mis",        32'(mis),        32'(mMis));
    check("mis_sticky", 32'(mis_sticky), 32'(mSticky));
    check("fault",      32'(fault),      32'(fv));
    check("err_cnt",    32'(err_cnt),    32'(mCnt));
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [WIDTH-1:0] a, b, c, input logic clrV, rstV);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; clr = clrV; rst = rstV;
    modelStep(a, b, c, clrV, rstV);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    logic [WIDTH-1:0] base, ra, rb, rc;
    int mode;

    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    check("reset_all", {out, tmr_err, mis, mis_sticky, fault, err_cnt}, '0);

    // Unanimous inputs
    for (int i = 0; i < 5; i++) begin
      step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
      if (i == 0) check("first_out", 32'(out), 32'h5A);
    end
    check("clean_status", {tmr_err, mis, mis_sticky, fault, err_cnt}, '0);

    // Single-cycle minority on A
    step(8'h5B, 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("a_minority_mis", 32'(mis), 32'b001);
    step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("a_sticky_hold", 32'(mis_sticky), 32'b001);
    check("a_err_cnt", 32'(err_cnt), 32'd1);

    // Split bits implicate A and B; THRESH cycles faults both
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 8'h00, 8'h0F, 1'b0, 1'b0);
      if (i == 1) check("ab_no_fault_yet", 32'(fault), 32'b000);
    end
    check("ab_out", 32'(out), 32'h0F);
    check("ab_fault", 32'(fault), 32'b011);
    step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("ab_fault_sticky", 32'(fault), 32'b011);

    // C: run broken by a clean cycle, then three in a row
    step(8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b0);
    step(8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b0);
    step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
    step(8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b0);
    step(8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b0);
    check("c_run_reset", 32'(fault[2]), 32'd0);
    step(8'h5A, 8'h5A, 8'hA5, 1'b0, 1'b0);
    check("c_fault", 32'(fault[2]), 32'd1);

    // Counter saturation, then clear with an error present
    for (int i = 0; i < 20; i++) step(8'h5B, 8'h5A, 8'h5A, 1'b0, 1'b0);
    check("cnt_saturated", 32'(err_cnt), 32'hF);
    step(8'h5A, 8'h5A, 8'h5B, 1'b1, 1'b0);
    check("clr_cnt_one", 32'(err_cnt), 32'd1);
    check("clr_sticky", 32'(mis_sticky), 32'b100);
    check("clr_fault", 32'(fault), 32'b000);

    // Reset overrides clr and errors; first result one cycle after release
    step(8'hFF, 8'h00, 8'h0F, 1'b1, 1'b1);
    check("rst_mid_run", {out, tmr_err, mis, mis_sticky, fault, err_cnt}, '0);
    step(8'hFF, 8'h00, 8'h0F, 1'b0, 1'b0);
    check("post_rst_out", 32'(out), 32'h0F);

    // Random traffic biased towards minority corruption
    for (int i = 0; i < 600; i++) begin
      base = WIDTH'($urandom);
      ra = base; rb = base; rc = base;
      mode = $urandom_range(0, 4);
      case (mode)
        1: case ($urandom_range(0, 2))
             0: ra = base ^ WIDTH'($urandom);
             1: rb = base ^ WIDTH'($urandom);
             default: rc = base ^ WIDTH'($urandom);
           endcase
        2: begin ra = base ^ WIDTH'($urandom); rc = base ^ WIDTH'($urandom); end
        3: begin ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = WIDTH'($urandom); end
        default: ;
      endcase
      step(ra, rb, rc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
